falcon_modmul_pipe: RTL and testbench
=====================================

FALCON_MODMUL_PIPE -- requirements
Module: falcon_modmul_pipe

Interface
REQ-001 Parameter W, default 14, SHALL be the coefficient width; only 14 is supported.
REQ-002 Parameter Q, default 12289, SHALL be the modulus; only 12289 is supported.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL mark A, B, in_tag as valid this cycle.
REQ-006 in_ready  output  1  SHALL indicate the block accepts an input this cycle.
REQ-007 A  input  14  SHALL be the first operand, nominally in [0, 12288].
REQ-008 B  input  14  SHALL be the second operand (twiddle), nominally in [0, 12288].
REQ-009 in_tag  input  8  SHALL be a sideband tag (coefficient index) carried with the operands.
REQ-010 out_valid  output  1  SHALL mark C, out_tag, err as valid.
REQ-011 out_ready  input  1  SHALL indicate the downstream modsub/modadd stage consumes the output.
REQ-012 C  output  14  SHALL be (A*B) mod 12289, in [0, 12288].
REQ-013 out_tag  output  8  SHALL be the in_tag of the transaction presented on C.
REQ-014 err  output  1  SHALL flag an out-of-range operand (see Configuration).

Function
REQ-015 An input transfer SHALL occur when in_valid and in_ready are both high at a rising edge; an output transfer when out_valid and out_ready are both high.
REQ-016 The datapath SHALL be a 3-stage pipeline: S1 registers the 28-bit product A*B; S2 registers the Barrett remainder r = P - ((P*21843)>>28)*12289, r in [0, 24577]; S3 registers C = r if r < 12289, else r - 12289.
REQ-017 Result SHALL be bit-exact (A*B) mod 12289 for all A, B in [0, 12288]; no intermediate SHALL truncate below 28 bits (product) or 43 bits (Barrett estimate).
REQ-018 Each stage SHALL carry its own valid bit plus the tag; tag and err SHALL stay aligned with data.
REQ-019 Pipeline enable SHALL be en = !out_valid || out_ready; all stages advance only when en is high; in_ready SHALL equal en combinationally.
REQ-020 With out_ready held high, latency SHALL be 3 cycles from input transfer to out_valid, throughput one result per cycle.
REQ-021 With out_ready low and out_valid high, C, out_tag, err, out_valid and all internal stage contents SHALL hold unchanged; no transaction is lost or duplicated.
REQ-022 A bubble (in_valid low while en high) SHALL propagate as an invalid stage; bubbles are not collapsed.
REQ-023 Transactions SHALL exit in acceptance order.
REQ-024 Simultaneous input and output transfer in the same cycle SHALL both complete.

Reset
REQ-025 While rst_n is low, all stage valid bits, out_valid and err SHALL be 0; C and out_tag SHALL be 0.
REQ-026 Reset assertion mid-operation SHALL discard all in-flight transactions immediately, regardless of clk.
REQ-027 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-028 The first input transfer SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro FALCON_MODMUL_ERR_EN SHALL compile in operand range checking.
REQ-030 With FALCON_MODMUL_ERR_EN defined, err SHALL be 1 for a transaction whose A >= 12289 or B >= 12289, aligned with that transaction's C; C SHALL still equal (A*B) mod 12289 for all 14-bit inputs.
REQ-031 Without FALCON_MODMUL_ERR_EN, err SHALL be tied to 0, no check logic is generated, and the port list is unchanged.

Verification
REQ-032 A=1234, B=5678, tag=0x11, out_ready=1 -> out_valid exactly 3 cycles later, C=1922, out_tag=0x11, err=0.
REQ-033 A=12288, B=12288 -> C=1; A=2, B=6145 -> C=1; A=0, B=5000 -> C=0.
REQ-034 8 back-to-back inputs (tags 0..7), out_ready low for cycles 4-6 -> outputs held stable while stalled, in_ready low, all 8 results delivered once in tag order.
REQ-035 Three transactions in flight, rst_n pulsed low asynchronously -> out_valid=0 immediately, no stale result ever appears after reset release.
REQ-036 FALCON_MODMUL_ERR_EN defined, A=12289, B=1 -> C=0, err=1; following A=5, B=7 -> C=35, err=0; macro undefined -> err=0 for both.

Source files
------------

// File: rtl/falcon_modmul_pipe.sv
// falcon_modmul_pipe: 3-stage pipelined (A*B) mod 12289 Barrett multiplier with valid/ready flow control.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid, in_ready    - input handshake (in_ready = pipeline enable)
//   A, B, in_tag          - operands and sideband tag
//   out_valid, out_ready  - output handshake
//   C, out_tag, err       - result, tag of that result, out-of-range operand flag
// Optional macro FALCON_MODMUL_ERR_EN compiles in operand range checking; otherwise err is tied to 0.
module falcon_modmul_pipe #(
    parameter int W = 14,
    parameter int Q = 12289
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [7:0]   in_tag,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] C,
    output logic [7:0]   out_tag,
    output logic         err
);
    localparam int PW = 2 * W;
    localparam int EW = PW + 15;
    localparam int RW = W + 1;
    localparam logic [EW-1:0] MU = EW'(21843);
    localparam logic [PW-1:0] QP = PW'(Q);
    localparam logic [RW-1:0] QR = RW'(Q);
    logic            en;
    logic            v1_q, v2_q, v3_q;
    logic [PW-1:0]   p1_q, p1_d;
    logic [RW-1:0]   r2_q, r2_d;
    logic [W-1:0]    c3_q, c3_d;
    logic [7:0]      t1_q, t2_q, t3_q;
    logic [EW-1:0]   est;
    logic [14:0]     q_est;
    logic [PW-1:0]   qm;
    assign en       = !v3_q || out_ready;
    assign in_ready = en;
    assign p1_d  = {{W{1'b0}}, A} * {{W{1'b0}}, B};
    // Barrett estimate: q_est is floor(P/Q) or one less, so the remainder lands in [0, 2Q).
    assign est   = {15'd0, p1_q} * MU;
    assign q_est = 15'(est >> PW);
    assign qm    = {{(PW-15){1'b0}}, q_est} * QP;
    assign r2_d  = RW'(p1_q - qm);
    assign c3_d  = W'(r2_q >= QR ? r2_q - QR : r2_q);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            p1_q <= '0;
            r2_q <= '0;
            c3_q <= '0;
            t1_q <= '0;
            t2_q <= '0;
            t3_q <= '0;
        end else if (en) begin
            v1_q <= in_valid;
            p1_q <= p1_d;
            t1_q <= in_tag;
            v2_q <= v1_q;
            r2_q <= r2_d;
            t2_q <= t1_q;
            v3_q <= v2_q;
            c3_q <= c3_d;
            t3_q <= t2_q;
        end
    end
    assign out_valid = v3_q;
    assign C         = c3_q;
    assign out_tag   = t3_q;
`ifdef FALCON_MODMUL_ERR_EN
    localparam logic [W-1:0] QW = W'(Q);
    logic e1_q, e2_q, e3_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1_q <= 1'b0;
            e2_q <= 1'b0;
            e3_q <= 1'b0;
        end else if (en) begin
            e1_q <= (A >= QW) || (B >= QW);
            e2_q <= e1_q;
            e3_q <= e2_q;
        end
    end
    assign err = e3_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_falcon_modmul_pipe.sv
// tb_falcon_modmul_pipe: directed self-checking bench for falcon_modmul_pipe.
module tb_falcon_modmul_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [13:0] A = '0;
    logic [13:0] B = '0;
    logic [7:0]  in_tag = '0;
    logic        in_ready, out_valid, err;
    logic [13:0] C;
    logic [7:0]  out_tag;
    int checks = 0;
    int errors = 0;
    int va [8];
    int vb [8];
    int ve [8];
    int sent, got;
`ifdef FALCON_MODMUL_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    falcon_modmul_pipe #(.W(14), .Q(12289)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .C(C), .out_tag(out_tag), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", nm, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int a, input int b, input int t);
        in_valid = v;
        A = 14'(a);
        B = 14'(b);
        in_tag = 8'(t);
    endtask

    initial begin
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_C", 32'(C), 0);
        chk("rst_out_tag", 32'(out_tag), 0);
        chk("rst_err", 32'(err), 0);
        @(negedge clk);
        @(negedge clk);
        // release reset and present the first transfer for the very next edge
        rst_n = 1'b1;
        drive(1, 1234, 5678, 8'h11);
        @(negedge clk);
        drive(0, 0, 0, 0);
        chk("lat_c1_valid", 32'(out_valid), 0);
        @(negedge clk);
        chk("lat_c2_valid", 32'(out_valid), 0);
        @(negedge clk);
        chk("lat_c3_valid", 32'(out_valid), 1);
        chk("lat_C", 32'(C), 1922);
        chk("lat_tag", 32'(out_tag), 32'h11);
        chk("lat_err", 32'(err), 0);
        @(negedge clk);
        chk("lat_c4_valid", 32'(out_valid), 0);

        drive(1, 12288, 12288, 1);
        @(negedge clk);
        drive(1, 2, 6145, 2);
        @(negedge clk);
        drive(1, 0, 5000, 3);
        @(negedge clk);
        drive(0, 0, 0, 0);
        chk("max_valid", 32'(out_valid), 1);
        chk("max_C", 32'(C), 1);
        chk("max_tag", 32'(out_tag), 1);
        @(negedge clk);
        chk("wrap_C", 32'(C), 1);
        chk("wrap_tag", 32'(out_tag), 2);
        @(negedge clk);
        chk("zero_C", 32'(C), 0);
        chk("zero_tag", 32'(out_tag), 3);
        @(negedge clk);
        chk("drain_valid", 32'(out_valid), 0);

        for (int i = 0; i < 8; i++) begin
            va[i] = 1000 + 1500 * i;
            vb[i] = 777 + i;
            ve[i] = (va[i] * vb[i]) % 12289;
        end
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 6);
            if (sent < 8) drive(1, va[sent], vb[sent], sent);
            else drive(0, 0, 0, 0);
            #1;
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", 32'(in_ready), 0);
                chk("stall_C_hold", 32'(C), 32'(ve[got]));
                chk("stall_tag_hold", 32'(out_tag), 32'(got));
            end
            if (out_valid && out_ready) begin
                chk("bb_no_dup", 32'(got < 8), 1);
                chk("bb_C", 32'(C), 32'(ve[got]));
                chk("bb_tag", 32'(out_tag), 32'(got));
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        drive(0, 0, 0, 0);
        out_ready = 1'b1;
        chk("bb_sent", 32'(sent), 8);
        chk("bb_got", 32'(got), 8);

        drive(1, 100, 200, 8'h41);
        @(negedge clk);
        drive(1, 300, 400, 8'h42);
        @(negedge clk);
        drive(1, 500, 600, 8'h43);
        @(posedge clk);
        #2;
        drive(0, 0, 0, 0);
        chk("pre_rst_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_C", 32'(C), 0);
        chk("async_rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_no_stale", 32'(out_valid), 0);
        end

        drive(1, 12289, 1, 8'h21);
        @(negedge clk);
        drive(1, 5, 7, 8'h22);
        @(negedge clk);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("err_valid", 32'(out_valid), 1);
        chk("err_C", 32'(C), 0);
        chk("err_flag", 32'(err), 32'(ERR_EXP));
        chk("err_tag", 32'(out_tag), 32'h21);
        @(negedge clk);
        chk("ok_C", 32'(C), 35);
        chk("ok_err", 32'(err), 0);
        chk("ok_tag", 32'(out_tag), 32'h22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
